// File: rtl/lcd_spi_serializer_if.sv
// ============================================================================
// Module      : lcd_spi_serializer_if
// Description : Host-side byte handshake between an upstream source and the
//               LCD SPI serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_spi_serializer_if;
    logic [7:0]  data_in;
    logic        start;
    logic [15:0] div_factor;
    logic        command;
    logic        busy;
    logic        avail;

    modport master (
        output data_in, start, div_factor, command,
        input  busy, avail
    );

    modport slave (
        input  data_in, start, div_factor, command,
        output busy, avail
    );
endinterface

`default_nettype wire

// File: rtl/lcd_spi_serializer.sv
// ============================================================================
// Module      : lcd_spi_serializer
// Description : Mode-0 SPI byte serializer for a D/C-style LCD, with a
//               power-on LCD reset pulse. Optional byte counter output is
//               enabled by defining LCD_SPI_BYTE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_spi_serializer #(
    parameter int RST_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 Reset,
    lcd_spi_serializer_if.slave  bus,
    output logic                 mosi,
    output logic                 sclk,
    output logic                 sce,
    output logic                 dc,
    output logic                 rst
`ifdef LCD_SPI_BYTE_COUNT_EN
    ,
    output logic [15:0]          tx_count
`endif
);

    localparam logic [2:0] c_RST_LCD = 3'd0;
    localparam logic [2:0] c_IDLE    = 3'd1;
    localparam logic [2:0] c_LOAD    = 3'd2;
    localparam logic [2:0] c_SHIFT   = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam int              c_RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RW-1:0] c_RST_LAST = c_RW'(RST_CYCLES - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [c_RW-1:0] r_rst_cnt;
    logic [15:0]     r_cnt;
    logic [15:0]     r_div;
    logic [4:0]      r_edge;
    logic [7:0]      r_shift;
    logic            r_dc;
    logic [15:0]     w_div;
    logic            w_edge;
    logic            w_busy;
    logic            w_avail;

    // In LOAD the divider is still on the input; a zero divider behaves as 1
    assign w_div  = (r_state == c_LOAD)
                  ? ((bus.div_factor == 16'd0) ? 16'd1 : bus.div_factor)
                  : r_div;
    // An sclk edge takes effect in the cycle after w_edge is seen
    assign w_edge = ((r_state == c_LOAD) || (r_state == c_SHIFT))
                  && ((r_cnt + 16'd1) == w_div);

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_RST_LCD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_RST_LCD: if (r_rst_cnt == c_RST_LAST) w_next = c_IDLE;
            c_IDLE:    if (bus.start) w_next = c_LOAD;
            c_LOAD:    w_next = c_SHIFT;
            c_SHIFT:   if (w_edge && (r_edge == 5'd15)) w_next = c_DONE;
            c_DONE:    w_next = bus.start ? c_LOAD : c_IDLE;
            default:   w_next = c_RST_LCD;
        endcase
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_rst_cnt <= '0;
            r_cnt     <= 16'd0;
            r_div     <= 16'd1;
            r_edge    <= 5'd0;
            r_shift   <= 8'd0;
            r_dc      <= 1'b0;
        end else begin
            r_rst_cnt <= (r_state == c_RST_LCD) ? r_rst_cnt + 1'b1 : '0;
            if (r_state == c_LOAD) begin
                r_shift <= bus.data_in;
                r_dc    <= bus.command;
                r_div   <= w_div;
            end
            if ((r_state == c_LOAD) || (r_state == c_SHIFT)) begin
                if (w_edge) begin
                    r_cnt  <= 16'd0;
                    r_edge <= r_edge + 5'd1;
                    // Odd edge count means sclk is high, so this edge falls
                    if ((r_state == c_SHIFT) && r_edge[0]) begin
                        r_shift <= {r_shift[6:0], 1'b0};
                    end
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else begin
                r_cnt  <= 16'd0;
                r_edge <= 5'd0;
            end
        end
    end

    always_comb begin
        mosi    = 1'b0;
        sclk    = 1'b0;
        sce     = 1'b1;
        dc      = r_dc;
        rst     = 1'b1;
        w_busy  = 1'b1;
        w_avail = 1'b0;
        case (r_state)
            c_RST_LCD: rst = 1'b0;
            c_IDLE:    w_busy = 1'b0;
            c_LOAD: begin
                sce  = 1'b0;
                dc   = bus.command;
                mosi = bus.data_in[7];
            end
            c_SHIFT: begin
                sce  = 1'b0;
                sclk = r_edge[0];
                mosi = r_shift[7];
            end
            c_DONE:    w_avail = 1'b1;
            default:   rst = 1'b0;
        endcase
    end

    assign bus.busy  = w_busy;
    assign bus.avail = w_avail;

`ifdef LCD_SPI_BYTE_COUNT_EN
    logic [15:0] r_tx_count;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_tx_count <= 16'd0;
        end else if (r_state == c_DONE) begin
            r_tx_count <= r_tx_count + 16'd1;
        end
    end

    assign tx_count = r_tx_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lcd_spi_serializer.sv
// ============================================================================
// Module      : tb_lcd_spi_serializer
// Description : Self-checking bench for lcd_spi_serializer (vector table plus
//               scoreboard fed by an SPI pin monitor).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_spi_serializer;

    typedef struct {
        logic [7:0]  data;
        logic        cmd;
        logic [15:0] div;
    } vec_t;

    logic clock;
    logic Reset;
    logic mosi, sclk, sce, dc, rst;
`ifdef LCD_SPI_BYTE_COUNT_EN
    logic [15:0] tx_count;
`endif

    lcd_spi_serializer_if bus ();

    lcd_spi_serializer #(.RST_CYCLES(16)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus),
        .mosi  (mosi),
        .sclk  (sclk),
        .sce   (sce),
        .dc    (dc),
        .rst   (rst)
`ifdef LCD_SPI_BYTE_COUNT_EN
        ,
        .tx_count (tx_count)
`endif
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_avail = 0;
    vec_t sb[$];
    vec_t vecs[6];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Pin monitor: rebuilds each byte from mosi on sclk rises, checks on avail
    logic       prev_sce = 1'b1, prev_sclk = 1'b0;
    logic       in_byte = 1'b0, unstable = 1'b0;
    logic [7:0] shreg = 8'd0;
    logic       hi_mosi = 1'b0, hi_dc = 1'b0, dc_seen = 1'b0;
    int         t_load = 0, nbits = 0;

    always @(negedge clock) begin
        if (!Reset) begin
            in_byte = 1'b0;
        end else begin
            if (prev_sce && !sce) begin
                in_byte  = 1'b1;
                t_load   = cyc;
                shreg    = 8'd0;
                nbits    = 0;
                unstable = 1'b0;
                dc_seen  = dc;
            end
            if (in_byte) begin
                if (!prev_sclk && sclk) begin
                    shreg   = {shreg[6:0], mosi};
                    nbits++;
                    hi_mosi = mosi;
                    hi_dc   = dc;
                end else if (prev_sclk && sclk && ((mosi != hi_mosi) || (dc != hi_dc))) begin
                    unstable = 1'b1;
                end
                if (!sce && (dc != dc_seen)) unstable = 1'b1;
            end
            if (bus.avail) begin
                n_avail++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_avail: got avail with empty scoreboard at cycle %0d", cyc);
                end else begin
                    vec_t e;
                    int   eff;
                    e   = sb.pop_front();
                    eff = (e.div == 16'd0) ? 1 : int'(e.div);
                    check("byte",      {24'd0, shreg}, {24'd0, e.data});
                    check("dc",        {31'd0, dc_seen}, {31'd0, e.cmd});
                    check("period",    cyc - t_load, 16 * eff);
                    check("bit_count", nbits, 8);
                    check("stable",    {31'd0, unstable}, 32'd0);
                    check("sce_done",  {31'd0, sce}, 32'd1);
                end
                in_byte = 1'b0;
            end
        end
        prev_sce  = sce;
        prev_sclk = sclk;
    end

    task automatic wait_avail(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (bus.avail) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL avail_timeout: got no avail within %0d cycles, expected a pulse", bound);
        end
    endtask

    // Release Reset and watch the LCD reset pulse; leaves start low
    task automatic rst_seq();
        int low_cnt;
        bit sce_act;
        low_cnt = 0;
        sce_act = 1'b0;
        @(posedge clock);
        #1 Reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            if (!rst) low_cnt++;
            if (!sce) sce_act = 1'b1;
        end
        check("rst_low_cycles", low_cnt, 16);
        check("no_sce_in_reset", {31'd0, sce_act}, 32'd0);
        @(negedge clock);
        check("rst_high_after", {31'd0, rst}, 32'd1);
        check("busy_low_cycle17", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
    endtask

    task automatic send(input vec_t v);
        bit ok;
        @(posedge clock);
        #1;
        bus.data_in    = v.data;
        bus.command    = v.cmd;
        bus.div_factor = v.div;
        bus.start      = 1'b1;
        sb.push_back(v);
        @(posedge clock);
        #1 bus.start = 1'b0;
        @(posedge clock);
        #1;
        bus.data_in    = ~v.data;
        bus.command    = ~v.cmd;
        bus.div_factor = v.div + 16'd3;
        wait_avail(400, ok);
        @(negedge clock);
        check("idle_pins", {27'd0, bus.busy, mosi, sclk, sce, dc},
                           {27'd0, 1'b0, 1'b0, 1'b0, 1'b1, v.cmd});
    endtask

    initial begin
        bit ok;
        int t1, t_abort, avail_before;

        vecs[0] = '{8'hA5, 1'b1, 16'd2};
        vecs[1] = '{8'h3C, 1'b0, 16'd1};
        vecs[2] = '{8'hFF, 1'b1, 16'd3};
        vecs[3] = '{8'h00, 1'b0, 16'd0};
        vecs[4] = '{8'h81, 1'b1, 16'd1};
        vecs[5] = '{8'h5A, 1'b0, 16'd4};

        Reset          = 1'b0;
        bus.start      = 1'b1;
        bus.data_in    = 8'h00;
        bus.command    = 1'b0;
        bus.div_factor = 16'd2;
        #2;
        check("reset_pins", {25'd0, mosi, sclk, sce, dc, rst, bus.avail, bus.busy},
                            {25'd0, 7'b0010001});
        repeat (3) @(posedge clock);
        rst_seq();

        for (int i = 0; i < 6; i++) send(vecs[i]);

        // Back-to-back: upstream swaps data_in on avail
        @(posedge clock);
        #1;
        bus.data_in    = 8'h21;
        bus.command    = 1'b0;
        bus.div_factor = 16'd2;
        bus.start      = 1'b1;
        sb.push_back('{8'h21, 1'b0, 16'd2});
        sb.push_back('{8'h90, 1'b0, 16'd2});
        wait_avail(200, ok);
        t1 = cyc;
        check("b2b_sce_high", {31'd0, sce}, 32'd1);
        bus.data_in = 8'h90;
        @(negedge clock);
        check("b2b_sce_gap", {31'd0, sce}, 32'd0);
        check("b2b_avail_one", {31'd0, bus.avail}, 32'd0);
        wait_avail(200, ok);
        check("b2b_period", cyc - t1, 33);
        bus.start = 1'b0;
        @(negedge clock);
        check("b2b_idle", {31'd0, bus.busy}, 32'd0);
        check("b2b_sb_empty", sb.size(), 0);

        // Reset during a byte in flight
        @(posedge clock);
        #1;
        bus.data_in    = 8'hFF;
        bus.command    = 1'b1;
        bus.div_factor = 16'd2;
        bus.start      = 1'b1;
        sb.push_back('{8'hFF, 1'b1, 16'd2});
        @(posedge clock);
        #1 bus.start = 1'b0;
        t_abort = cyc;
        avail_before = n_avail;
        repeat (10) @(posedge clock);
        #2 Reset = 1'b0;
        #1;
        check("abort_cycle", cyc - t_abort, 10);
        check("abort_pins", {25'd0, mosi, sclk, sce, dc, rst, bus.avail, bus.busy},
                            {25'd0, 7'b0010001});
        repeat (4) @(posedge clock);
        check("abort_no_avail", n_avail - avail_before, 0);
        check("abort_sb_left", sb.size(), 1);
        sb.delete();
        rst_seq();

`ifdef LCD_SPI_BYTE_COUNT_EN
        check("tx_count_reset", {16'd0, tx_count}, 32'd0);
        for (int i = 0; i < 3; i++) send(vecs[i]);
        check("tx_count_3", {16'd0, tx_count}, 32'd3);
`endif

        repeat (5) @(negedge clock);
        check("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/lcd_spi_serializer.md
LCD_SPI_SERIALIZER -- requirements
Module: lcd_spi_serializer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: clock cycles LCD rst is held low after Reset release.
REQ-002 SHALL have port clock  input  1: single clock; all state changes on posedge.
REQ-003 SHALL have port Reset  input  1: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port data_in  input  8: byte to transmit, MSB first.
REQ-005 SHALL have port start  input  1: level; while high, bytes are transmitted back to back.
REQ-006 SHALL have port div_factor  input  16: sclk half-period in clock cycles.
REQ-007 SHALL have port command  input  1: LCD D/C level for the byte (0 = command, 1 = display data).
REQ-008 SHALL have ports mosi, sclk, sce, dc, rst  output  1 each: LCD serial pins; sce and rst are active-low.
REQ-009 SHALL have ports busy, avail  output  1 each: busy = transfer or LCD reset in progress; avail = one-cycle byte-done strobe.

Function
REQ-010 SHALL implement states RST_LCD, IDLE, LOAD, SHIFT, DONE.
REQ-011 SHALL hold rst low in RST_LCD for RST_CYCLES cycles, then drive rst high and enter IDLE.
REQ-012 SHALL drive busy high in RST_LCD, LOAD, SHIFT and DONE, and low only in IDLE.
REQ-013 SHALL move IDLE->LOAD on the first cycle start is high.
REQ-014 SHALL capture data_in, command and div_factor in LOAD; a captured div_factor of 0 SHALL be treated as 1; later input changes SHALL not affect the byte in flight.
REQ-015 SHALL drive sce low, sclk low, dc = command and mosi = data bit7 in the LOAD cycle (call it T).
REQ-016 SHALL raise sclk at T+k*div, k odd, and lower it at T+k*div, k even, for k = 1..16, in SPI mode 0.
REQ-017 SHALL update mosi to the next bit on each sclk falling edge (k = 2, 4, ..., 14).
REQ-018 SHALL keep mosi and dc stable while sclk is high.
REQ-019 SHALL enter DONE at T+16*div, driving sce high and avail high for exactly that one cycle.
REQ-020 SHALL go DONE->LOAD when start is high, and DONE->IDLE when it is low; byte period is therefore 16*div+1 cycles.
REQ-021 SHALL sample data_in in the LOAD cycle one cycle after avail, so an upstream that updates data_in on avail is honoured.
REQ-022 SHALL complete a byte in flight when start falls mid-byte, then go IDLE without sending another byte.
REQ-023 SHALL ignore start during RST_LCD.
REQ-024 SHALL hold dc at its last captured value in IDLE; mosi SHALL be 0 in IDLE.

Reset
REQ-025 SHALL, on Reset low, immediately force mosi=0, sclk=0, sce=1, dc=0, rst=0, avail=0, busy=1 and state=RST_LCD, and clear all counters.
REQ-026 SHALL abort any byte in flight when Reset asserts mid-byte, with no avail pulse, and restart the LCD reset sequence after release.

Configuration
REQ-027 SHALL, with macro LCD_SPI_BYTE_COUNT_EN defined, add output tx_count[15:0], reset to 0, incremented on each avail pulse and wrapping 0xFFFF->0x0000.
REQ-028 SHALL, without LCD_SPI_BYTE_COUNT_EN, have no tx_count port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL cover: Reset release, RST_CYCLES=16 -> rst low for 16 cycles then high; busy low from cycle 17; start=1 during reset -> no sce activity.
REQ-030 SHALL cover: div_factor=2, data_in=0xA5, command=1, start pulsed 1 cycle -> mosi 1,0,1,0,0,1,0,1 on sclk rises at T+2,6,...,30; dc=1; avail at T+32 only; then IDLE.
REQ-031 SHALL cover: start held, data_in 0x21 then 0x90 changed on avail -> second LOAD at T+33 sends 0x90; sce high exactly 1 cycle between bytes.
REQ-032 SHALL cover: div_factor=0 -> byte completes in 17 cycles, identical to div_factor=1.
REQ-033 SHALL cover: Reset asserted at T+10 of a 0xFF byte -> outputs reach reset values in the same cycle; no avail; rst low 16 cycles after release.
REQ-034 SHALL cover: with LCD_SPI_BYTE_COUNT_EN, 3 bytes sent -> tx_count=3; preload 0xFFFF plus one byte -> tx_count=0.
